// File: rtl/lfsr_pkg.sv
// Shared definitions for the 6-bit game LFSR: width, seed, polynomial and checker states.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 6;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 6'h3F;

  typedef enum logic [1:0] {
    SEARCH,
    SYNC,
    LOCKED
  } chk_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[4:0], v[0] ^ v[1] ^ v[2] ^ v[4]};
  endfunction

endpackage

// File: rtl/lfsr_sequence_checker.sv
// Receive-side checker for the game LFSR stream: locks a local predictor and counts mispredictions.
// Define LFSR_CHECK_SATURATE_EN to make error_count saturate instead of wrapping.
module lfsr_sequence_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned MISS_LIMIT = 3,
  parameter int unsigned ERR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_value,
  output logic              locked,
  output logic              error_pulse,
  output logic              lost_pulse,
  output logic [ERR_W-1:0]  error_count
);

  chk_state_t        state_q, state_d;
  logic [LFSR_W-1:0] pred_q, pred_d;
  logic [3:0]        match_q, match_d;
  logic [3:0]        miss_q, miss_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              err_pulse_q, err_pulse_d;
  logic              lost_q, lost_d;
  logic [ERR_W-1:0]  err_inc;
  logic [3:0]        match_inc, miss_inc;

`ifdef LFSR_CHECK_SATURATE_EN
  assign err_inc = (err_q == '1) ? err_q : err_q + ERR_W'(1);
`else
  assign err_inc = err_q + ERR_W'(1);
`endif

  assign match_inc = match_q + 4'd1;
  assign miss_inc  = miss_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_d       = err_q;
    err_pulse_d = 1'b0;
    lost_d      = 1'b0;
    if (in_valid) begin
      case (state_q)
        SEARCH: begin
          // All-zero is the LFSR lock-up value and cannot seed the predictor.
          if (in_value != '0) begin
            pred_d  = lfsr_next(in_value);
            match_d = '0;
            state_d = SYNC;
          end
        end
        SYNC: begin
          if (in_value == pred_q) begin
            pred_d = lfsr_next(pred_q);
            if (match_inc == LOCK_COUNT[3:0]) begin
              match_d = '0;
              miss_d  = '0;
              state_d = LOCKED;
            end else begin
              match_d = match_inc;
            end
          end else if (in_value != '0) begin
            pred_d  = lfsr_next(in_value);
            match_d = '0;
          end else begin
            match_d = '0;
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          // Free-run from the predictor so a corrupted sample cannot derail it.
          pred_d = lfsr_next(pred_q);
          if (in_value == pred_q) begin
            miss_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            err_d       = err_inc;
            if (miss_inc == MISS_LIMIT[3:0]) begin
              lost_d  = 1'b1;
              miss_d  = '0;
              state_d = SEARCH;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= SEARCH;
      pred_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      err_q       <= '0;
      err_pulse_q <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      err_q       <= err_d;
      err_pulse_q <= err_pulse_d;
      lost_q      <= lost_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign error_pulse = err_pulse_q;
  assign lost_pulse  = lost_q;
  assign error_count = err_q;

endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// Directed self-checking bench for lfsr_sequence_checker.
module tb_lfsr_sequence_checker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [5:0] in_value;
  logic       locked;
  logic       error_pulse;
  logic       lost_pulse;
  logic [7:0] error_count;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  lfsr_sequence_checker dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_value   (in_value),
    .locked     (locked),
    .error_pulse(error_pulse),
    .lost_pulse (lost_pulse),
    .error_count(error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed stream: 3F 3E 3D 3B 37 2E 1C 38 31 22
  logic [5:0] lock_seq [5] = '{6'h3F, 6'h3E, 6'h3D, 6'h3B, 6'h37};

  task automatic send(input logic [5:0] v);
    in_valid = 1'b1;
    in_value = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_value = 6'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  task automatic lock_stream();
    for (int i = 0; i < 5; i++) send(lock_seq[i]);
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (locked !== 1'b0) $display("FAIL reset_locked got %0b want 0", locked);
    else pass_cnt++;
    total_cnt++;
    if (error_count !== 8'd0) $display("FAIL reset_count got %0d want 0", error_count);
    else pass_cnt++;
    total_cnt++;
    if ({error_pulse, lost_pulse} !== 2'b00)
      $display("FAIL reset_pulses got %b want 00", {error_pulse, lost_pulse});
    else pass_cnt++;
  endtask

  task automatic test_lock();
    for (int i = 0; i < 4; i++) send(lock_seq[i]);
    total_cnt++;
    if (locked !== 1'b0) $display("FAIL lock_early got %0b want 0", locked);
    else pass_cnt++;
    send(6'h37);
    total_cnt++;
    if (locked !== 1'b1) $display("FAIL lock_after_37 got %0b want 1", locked);
    else pass_cnt++;
    total_cnt++;
    if (error_count !== 8'd0) $display("FAIL lock_count got %0d want 0", error_count);
    else pass_cnt++;
  endtask

  task automatic test_single_error();
    send(6'h00);  // expected 2E
    total_cnt++;
    if ({locked, error_pulse, lost_pulse} !== 3'b110)
      $display("FAIL single_err_flags got %b want 110", {locked, error_pulse, lost_pulse});
    else pass_cnt++;
    total_cnt++;
    if (error_count !== 8'd1) $display("FAIL single_err_count got %0d want 1", error_count);
    else pass_cnt++;
    send(6'h1C);
    total_cnt++;
    if ({locked, error_pulse} !== 2'b10)
      $display("FAIL single_err_recover got %b want 10", {locked, error_pulse});
    else pass_cnt++;
    idle(1);
    total_cnt++;
    if (error_pulse !== 1'b0) $display("FAIL idle_pulse got %0b want 0", error_pulse);
    else pass_cnt++;
  endtask

  task automatic test_loss_relock();
    // Predictions are 38, 31, 22; none equal 15.
    send(6'h15);
    send(6'h15);
    total_cnt++;
    if ({locked, error_pulse, lost_pulse} !== 3'b110)
      $display("FAIL loss_second got %b want 110", {locked, error_pulse, lost_pulse});
    else pass_cnt++;
    send(6'h15);
    total_cnt++;
    if ({locked, error_pulse, lost_pulse} !== 3'b011)
      $display("FAIL loss_third got %b want 011", {locked, error_pulse, lost_pulse});
    else pass_cnt++;
    total_cnt++;
    if (error_count !== 8'd4) $display("FAIL loss_count got %0d want 4", error_count);
    else pass_cnt++;
    send(6'h3F);
    total_cnt++;
    if (lost_pulse !== 1'b0) $display("FAIL lost_one_cycle got %0b want 0", lost_pulse);
    else pass_cnt++;
    for (int i = 1; i < 5; i++) send(lock_seq[i]);
    total_cnt++;
    if (locked !== 1'b1) $display("FAIL relock got %0b want 1", locked);
    else pass_cnt++;
    total_cnt++;
    if (error_count !== 8'd4) $display("FAIL relock_count got %0d want 4", error_count);
    else pass_cnt++;
  endtask

  task automatic test_zero_gaps();
    do_reset();
    repeat (4) send(6'h00);
    total_cnt++;
    if (locked !== 1'b0) $display("FAIL zero_search got %0b want 0", locked);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      send(lock_seq[i]);
      if (i < 4) idle(5);
    end
    total_cnt++;
    if (locked !== 1'b1) $display("FAIL gap_lock got %0b want 1", locked);
    else pass_cnt++;
    total_cnt++;
    if (error_count !== 8'd0) $display("FAIL gap_count got %0d want 0", error_count);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    send(6'h00);  // expected 2E
    send(6'h00);  // expected 1C
    total_cnt++;
    if ({locked, error_count} !== {1'b1, 8'd2})
      $display("FAIL mid_pre got %b/%0d want 1/2", locked, error_count);
    else pass_cnt++;
    rst      = 1'b0;
    in_valid = 1'b1;
    in_value = 6'h00;
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    total_cnt++;
    if ({locked, error_pulse, lost_pulse} !== 3'b000)
      $display("FAIL mid_flags got %b want 000", {locked, error_pulse, lost_pulse});
    else pass_cnt++;
    total_cnt++;
    if (error_count !== 8'd0) $display("FAIL mid_count got %0d want 0", error_count);
    else pass_cnt++;
  endtask

  task automatic test_counter_limit();
    logic [7:0] exp_final;
`ifdef LFSR_CHECK_SATURATE_EN
    exp_final = 8'd255;
`else
    exp_final = 8'd0;
`endif
    do_reset();
    repeat (85) begin
      lock_stream();
      repeat (3) send(6'h15);
    end
    total_cnt++;
    if (error_count !== 8'd255) $display("FAIL limit_255 got %0d want 255", error_count);
    else pass_cnt++;
    lock_stream();
    send(6'h00);
    total_cnt++;
    if (error_count !== exp_final)
      $display("FAIL limit_256 got %0d want %0d", error_count, exp_final);
    else pass_cnt++;
    total_cnt++;
    if (error_pulse !== 1'b1) $display("FAIL limit_pulse got %0b want 1", error_pulse);
    else pass_cnt++;
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_value = 6'h00;
    test_reset();
    test_lock();
    test_single_error();
    test_loss_relock();
    test_zero_gaps();
    test_reset_mid();
    test_counter_limit();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
